synthia_poly: RTL and testbench

Parametrised polyphonic successor to the single-voice Synthia tone generator. Takes the 13-key keyboard (C4..C5), a mode button and an octave button, allocates up to NUM_VOICES simultaneously pressed keys to phase-accumulator voices, and renders square, sawtooth or triangle waves. The voices are mixed, averaged and driven out as an 8-bit PWM stream on a single pin. It sits directly behind the Caravel GPIO pads and runs on the 10 MHz design clock.

---
 rtl/synthia_poly.sv | 224 ++++++++++++++++++++++
 tb/tb_synthia_poly.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/synthia_poly.sv
`timescale 1ns/1ps
// synthia_poly: polyphonic square/saw/triangle tone generator. Held keys are given to
// phase-accumulator voices lowest-first; the voices are averaged and sent out as 8-bit PWM.
module synthia_poly #(
  parameter int NUM_VOICES = 2,
  parameter int ACC_WIDTH  = 24,
  parameter int OCT_STEPS  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [12:0] pb,
  input  logic        modes,
  input  logic        octaves,
  output logic        PWM_o,
  output logic [1:0]  mode_o,
  output logic [1:0]  octave_o,
  output logic [3:0]  voices_o
);

  localparam int KEYS = 13;
  localparam int LOGV = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 0;
  localparam int SUMW = 8 + LOGV;

  typedef enum logic [1:0] {
    MODE_SQUARE = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_TRI    = 2'd2
  } mode_e;

  logic [KEYS-1:0] pb_meta_q, pb_sync_q;
  logic            modes_meta_q, modes_sync_q, modes_prev_q;
  logic            oct_meta_q, oct_sync_q, oct_prev_q;
  logic            mode_rise, oct_rise;

  mode_e           mode_q, mode_d;
  logic [1:0]      oct_q, oct_d;

  logic [3:0]           alloc_cnt;
  logic [3:0]           key_d      [NUM_VOICES];
  logic [3:0]           key_q      [NUM_VOICES];
  logic [NUM_VOICES-1:0] act_d, act_q;
  logic [ACC_WIDTH-1:0] step_w     [NUM_VOICES];
  logic [ACC_WIDTH-1:0] phase_d    [NUM_VOICES];
  logic [ACC_WIDTH-1:0] phase_q    [NUM_VOICES];
  logic [7:0]           top_w      [NUM_VOICES];
  logic [7:0]           sample_d   [NUM_VOICES];
  logic [7:0]           sample_q   [NUM_VOICES];

  logic [SUMW-1:0] mix_sum;
  logic [7:0]      mix_d, mix_q;
  logic [7:0]      cnt_q, duty_q;
  logic            pwm_d, pwm_q;

  // All pad inputs are asynchronous; two flops before anything looks at them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pb_meta_q    <= '0;
      pb_sync_q    <= '0;
      modes_meta_q <= 1'b0;
      modes_sync_q <= 1'b0;
      modes_prev_q <= 1'b0;
      oct_meta_q   <= 1'b0;
      oct_sync_q   <= 1'b0;
      oct_prev_q   <= 1'b0;
    end else begin
      pb_meta_q    <= pb;
      pb_sync_q    <= pb_meta_q;
      modes_meta_q <= modes;
      modes_sync_q <= modes_meta_q;
      modes_prev_q <= modes_sync_q;
      oct_meta_q   <= octaves;
      oct_sync_q   <= oct_meta_q;
      oct_prev_q   <= oct_sync_q;
    end
  end

  assign mode_rise = modes_sync_q & ~modes_prev_q;
  assign oct_rise  = oct_sync_q & ~oct_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_SQUARE;
      oct_q  <= '0;
    end else begin
      mode_q <= mode_d;
      oct_q  <= oct_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (mode_rise) begin
      case (mode_q)
        MODE_SQUARE: mode_d = MODE_SAW;
        MODE_SAW:    mode_d = MODE_TRI;
        default:     mode_d = MODE_SQUARE;
      endcase
    end
  end

  always_comb begin
    oct_d = oct_q;
    if (oct_rise) begin
      oct_d = (oct_q == 2'(OCT_STEPS - 1)) ? 2'd0 : oct_q + 2'd1;
    end
  end

  // Voice v gets the v-th lowest held key; alloc_cnt ends up as the popcount.
  always_comb begin
    alloc_cnt = '0;
    act_d     = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      key_d[v] = '0;
    end
    for (int i = 0; i < KEYS; i++) begin
      if (pb_sync_q[i]) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (alloc_cnt == 4'(v)) begin
            key_d[v] = 4'(i);
            act_d[v] = 1'b1;
          end
        end
        alloc_cnt = alloc_cnt + 4'd1;
      end
    end
  end

  assign voices_o = !en ? 4'd0 :
                    (alloc_cnt > 4'(NUM_VOICES)) ? 4'(NUM_VOICES) : alloc_cnt;

  function automatic logic [ACC_WIDTH-1:0] base_step(input logic [3:0] key);
    logic [9:0] inc;
    case (key)
      4'd0:    inc = 10'd439;
      4'd1:    inc = 10'd465;
      4'd2:    inc = 10'd493;
      4'd3:    inc = 10'd522;
      4'd4:    inc = 10'd553;
      4'd5:    inc = 10'd586;
      4'd6:    inc = 10'd621;
      4'd7:    inc = 10'd658;
      4'd8:    inc = 10'd697;
      4'd9:    inc = 10'd738;
      4'd10:   inc = 10'd782;
      4'd11:   inc = 10'd829;
      4'd12:   inc = 10'd878;
      default: inc = 10'd0;
    endcase
    return {{(ACC_WIDTH - 10){1'b0}}, inc} << (ACC_WIDTH - 24);
  endfunction

  // A new key on a voice restarts its phase at 0; that wins over the accumulate.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      step_w[v] = base_step(key_q[v]) << oct_q;
      if (!en || !act_d[v] || !act_q[v] || (key_d[v] != key_q[v])) begin
        phase_d[v] = '0;
      end else begin
        phase_d[v] = phase_q[v] + step_w[v];
      end
      top_w[v] = phase_q[v][ACC_WIDTH-1 -: 8];
      case (mode_q)
        MODE_SQUARE: sample_d[v] = top_w[v][7] ? 8'd255 : 8'd0;
        MODE_SAW:    sample_d[v] = top_w[v];
        default:     sample_d[v] = top_w[v][7] ? ~{top_w[v][6:0], 1'b0}
                                               :  {top_w[v][6:0], 1'b0};
      endcase
      if (!act_q[v]) begin
        sample_d[v] = 8'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_q <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_q[v]    <= '0;
        phase_q[v]  <= '0;
        sample_q[v] <= '0;
      end
    end else begin
      act_q <= act_d;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_q[v]    <= key_d[v];
        phase_q[v]  <= phase_d[v];
        sample_q[v] <= sample_d[v];
      end
    end
  end

  always_comb begin
    mix_sum = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      mix_sum = mix_sum + SUMW'(sample_q[v]);
    end
    mix_d = en ? mix_sum[LOGV +: 8] : 8'd0;
  end

  // Duty only reloads at the counter wrap, so a period is never cut short.
  assign pwm_d = en & (cnt_q < duty_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mix_q  <= '0;
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      mix_q <= mix_d;
      cnt_q <= cnt_q + 8'd1;
      if (cnt_q == 8'hFF) begin
        duty_q <= mix_q;
      end
      pwm_q <= pwm_d;
    end
  end

  assign PWM_o    = pwm_q;
  assign mode_o   = mode_q;
  assign octave_o = oct_q;

endmodule

// File: tb/tb_synthia_poly.sv
`timescale 1ns/1ps
// Bench for synthia_poly: measures PWM duty per 256-cycle period and compares it
// with a duty predicted from key, mode and octave at the moment keys are pressed.
module tb_synthia_poly;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [12:0] pb = '0;
  logic        modes = 1'b0;
  logic        octaves = 1'b0;
  logic        PWM_o;
  logic [1:0]  mode_o;
  logic [1:0]  octave_o;
  logic [3:0]  voices_o;

  int cyc = 0;
  int n_vec = 0;
  int n_miss = 0;
  logic [7:0] exp_q[$];

  int base_tab[13] = '{439, 465, 493, 522, 553, 586, 621, 658, 697, 738, 782, 829, 878};
  int m_mode = 0;
  int m_oct  = 0;
  int m_org  = 0;
  int m_nk   = 0;
  int m_keys[2];

  synthia_poly #(
    .NUM_VOICES(2),
    .ACC_WIDTH(24),
    .OCT_STEPS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .pb(pb),
    .modes(modes),
    .octaves(octaves),
    .PWM_o(PWM_o),
    .mode_o(mode_o),
    .octave_o(octave_o),
    .voices_o(voices_o)
  );

  // clock / reset
  always #50 clk = ~clk;
  always @(posedge clk) if (reset) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // driver: keys change at a negedge; m_org is the last posedge before the change
  task automatic press_keys(input logic [12:0] v);
    pb    = v;
    m_org = cyc;
    m_nk  = 0;
    for (int i = 0; i < 13; i++) begin
      if (v[i] && m_nk < 2) begin
        m_keys[m_nk] = i;
        m_nk++;
      end
    end
  endtask

  // Duty loaded at wrap posedge n reflects the phase k = n - m_org - 6 steps in.
  function automatic int model_duty(input int n);
    int     k;
    int     sum;
    int     s;
    int     w;
    longint ph;
    k   = n - m_org - 6;
    sum = 0;
    for (int v = 0; v < m_nk; v++) begin
      ph = (longint'(k) * longint'(base_tab[m_keys[v]] << m_oct)) % 64'd16777216;
      s  = int'(ph / 65536);
      case (m_mode)
        0:       w = (s >= 128) ? 255 : 0;
        1:       w = s;
        default: w = (s >= 128) ? 255 - 2 * (s - 128) : 2 * s;
      endcase
      sum += w;
    end
    return sum / 2;
  endfunction

  // scoreboard: push predicted duty at each wrap, pop when its period has been counted
  task automatic run_periods(input string tag, input int num);
    int hi;
    for (int p = 0; p < num; p++) begin
      while (cyc % 256 != 0) @(negedge clk);
      exp_q.push_back(8'(model_duty(cyc)));
      hi = 0;
      repeat (256) begin
        @(negedge clk);
        hi += int'(PWM_o);
      end
      check_val(tag, hi, {24'd0, exp_q.pop_front()});
    end
  endtask

  task automatic count_pwm(input string tag, input int ncyc, input int exp);
    int hi;
    hi = 0;
    repeat (ncyc) begin
      @(negedge clk);
      hi += int'(PWM_o);
    end
    check_val(tag, hi, exp);
  endtask

  task automatic pulse_buttons(input logic m, input logic o, input int hold);
    int nm;
    int no;
    nm = m ? (m_mode + 1) % 3 : m_mode;
    no = o ? (m_oct + 1) % 2 : m_oct;
    modes   = m;
    octaves = o;
    wait_cyc(2);
    check_val("mode_pre", mode_o, m_mode);
    check_val("oct_pre", octave_o, m_oct);
    wait_cyc(1);
    check_val("mode_post", mode_o, nm);
    check_val("oct_post", octave_o, no);
    m_mode = nm;
    m_oct  = no;
    wait_cyc(hold);
    check_val("mode_hold", mode_o, m_mode);
    check_val("oct_hold", octave_o, m_oct);
    modes   = 1'b0;
    octaves = 1'b0;
    wait_cyc(4);
  endtask

  initial begin
    int seen;
    wait_cyc(3);
    check_val("rst_pwm", PWM_o, 0);
    check_val("rst_mode", mode_o, 0);
    check_val("rst_oct", octave_o, 0);
    check_val("rst_voices", voices_o, 0);
    reset = 1'b1;
    wait_cyc(1);
    check_val("rel_pwm", PWM_o, 0);
    check_val("rel_mode", mode_o, 0);
    check_val("rel_oct", octave_o, 0);
    check_val("rel_voices", voices_o, 0);
    count_pwm("idle_pwm", 1000, 0);

    // single C4, square
    en = 1'b1;
    wait_cyc($urandom_range(1, 5));
    press_keys(13'h0001);
    wait_cyc(1);
    check_val("voices_lat", voices_o, 0);
    wait_cyc(1);
    check_val("voices_c4", voices_o, 1);
    wait_cyc(6);
    run_periods("sq_c4_lo", 1);
    wait_until(m_org + 18950);
    run_periods("sq_c4_half", 2);
    wait_until(m_org + 38000);
    run_periods("sq_c4_wrap", 2);

    // held mode button advances once: SQUARE -> SAW
    pulse_buttons(1'b1, 1'b0, 50);
    press_keys(13'h0000);
    wait_cyc(5);
    press_keys(13'h0201);
    wait_cyc(2);
    check_val("voices_c4_a4", voices_o, 2);
    wait_cyc($urandom_range(6, 40));
    run_periods("saw_c4_a4", 6);

    // TRI on C5 around s=64 and s=192
    pulse_buttons(1'b1, 1'b0, 3);
    press_keys(13'h0000);
    wait_cyc(5);
    press_keys(13'h1000);
    wait_cyc(2);
    check_val("voices_c5", voices_o, 1);
    wait_cyc(6);
    run_periods("tri_c5", 2);
    wait_until(m_org + 4600);
    run_periods("tri_c5_s64", 1);
    wait_until(m_org + 14200);
    run_periods("tri_c5_s192", 1);

    // octave up with C5 held, then restart the note at the doubled step
    pulse_buttons(1'b0, 1'b1, 5);
    press_keys(13'h0000);
    wait_cyc(5);
    press_keys(13'h1000);
    wait_cyc(8);
    run_periods("tri_c5_oct1", 3);
    wait_until(m_org + 9400);
    run_periods("tri_c5_oct1_wrap", 1);

    // simultaneous edges: TRI->SQUARE and octave 1->0 together, then SAW
    pulse_buttons(1'b1, 1'b1, 5);
    pulse_buttons(1'b1, 1'b0, 5);

    // three keys on two voices, then reallocation
    press_keys(13'h0000);
    wait_cyc(5);
    press_keys(13'h0091);
    wait_cyc(2);
    check_val("voices_3keys", voices_o, 2);
    wait_cyc(6);
    run_periods("saw_3keys", 3);
    press_keys(13'h0090);
    wait_cyc(2);
    check_val("voices_realloc", voices_o, 2);
    wait_cyc(6);
    run_periods("saw_realloc", 3);

    // en low mutes from the next clock
    en = 1'b0;
    #1;
    check_val("voices_en_off", voices_o, 0);
    wait_cyc(1);
    check_val("pwm_en_off", PWM_o, 0);
    count_pwm("pwm_muted", 300, 0);

    // async reset while the output is high
    en = 1'b1;
    seen = 0;
    for (int i = 0; i < 2000 && seen == 0; i++) begin
      @(negedge clk);
      if (PWM_o === 1'b1) seen = 1;
    end
    check_val("pwm_seen_high", seen, 1);
    #5;
    reset = 1'b0;
    #1;
    check_val("async_rst_pwm", PWM_o, 0);
    check_val("async_rst_mode", mode_o, 0);
    check_val("async_rst_voices", voices_o, 0);
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
